// File: rtl/pc_sequencer.sv
// Program-counter owner at the ALU/fetch boundary: steps the fetch PC, redirects on
// resolved branches/jumps and holds a timed flush window over wrong-path work.
module pc_sequencer #(
  parameter int                 PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                 FLUSH_CYCLES = 2
) (
  input  logic                Clk_in,
  input  logic                Reset_in,
  input  logic                Stall_in,
  input  logic                Valid_in,
  input  logic                Branch_in,
  input  logic                Jump_in,
  input  logic [PC_WIDTH-1:0] Target_in,
  input  logic [PC_WIDTH-1:0] InstrPC_in,
  input  logic [PC_WIDTH-1:0] Offset_in,
  output logic [PC_WIDTH-1:0] PC_out,
  output logic [PC_WIDTH-1:0] PCPlus4_out,
  output logic                Redirect_out,
  output logic                Flush_out,
  output logic                Busy_out
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] WORD_MASK  = ~PC_WIDTH'(3);
  localparam logic [3:0]          FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t              state;
  logic [3:0]          flush_cnt;
  logic                req;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] redirect_target;

  always_comb begin
    req             = Valid_in & (Jump_in | Branch_in);
    jump_target     = Target_in & WORD_MASK;
    branch_target   = InstrPC_in + PC_STEP + (Offset_in << 2);
    redirect_target = Jump_in ? jump_target : branch_target;
  end

  assign PCPlus4_out = PC_out + PC_STEP;

  // A redirect wins over a stall; with a one-cycle flush the FSM never leaves RUN.
  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      state        <= RUN;
      flush_cnt    <= 4'd0;
      PC_out       <= RESET_PC;
      Redirect_out <= 1'b0;
      Flush_out    <= 1'b0;
      Busy_out     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          Redirect_out <= req;
          Flush_out    <= req;
          if (req) begin
            PC_out    <= redirect_target;
            flush_cnt <= FLUSH_LAST;
            if (FLUSH_CYCLES > 1) begin
              state    <= FLUSH;
              Busy_out <= 1'b1;
            end
          end else if (!Stall_in) begin
            PC_out <= PC_out + PC_STEP;
          end
        end
        FLUSH: begin
          Redirect_out <= 1'b0;
          if (flush_cnt == 4'd0) begin
            state     <= RUN;
            Flush_out <= 1'b0;
            Busy_out  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
            Flush_out <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
